latch_dump_serializer: RTL and testbench

//  Snapshots the four pipeline inter-stage latches on request and streams them as 32-bit words

---
 rtl/latch_dump_serializer.sv | 168 ++++++++++++++++
 tb/tb_latch_dump_serializer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_dump_serializer.sv
// latch_dump_serializer
// Takes a snapshot of the four pipeline inter-stage latches when a dump is
// requested. It then streams the snapshot into the UART TX FIFO as 32-bit
// words, low word first, behind a header word {MAGIC, 8'd11, seq}.
// The FIFO full flag can stall the stream at any word. While stalled, the
// current word is held and nothing is dropped or duplicated.
// Build option: define LATCH_DUMP_CHECKSUM_EN to append an XOR checksum
// word (header ^ D[0..10]) after the last data word.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for i_start; snapshot captured on the leaving edge
// HDR   | presenting header word
// DATA  | presenting snapshot word idx_q (0..10)
// CKSUM | presenting XOR checksum (checksum build only)
// DONE  | one-cycle o_done pulse; dump sequence number advances

module latch_dump_serializer #(
    parameter logic [7:0] MAGIC  = 8'hA5,
    parameter int         WORD_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [63:0]       i_IF_ID_latch,
    input  logic [138:0]      i_ID_EX_latch,
    input  logic [75:0]       i_EX_MEM_latch,
    input  logic [70:0]       i_MEM_WB_latch,
    input  logic              i_fifo_full,
    output logic [WORD_W-1:0] o_data_to_fifo,
    output logic              o_write_en_fifo,
    output logic              o_busy,
    output logic              o_done
);

    localparam int         SNAP_W   = 352;
    localparam int         N_DATA   = 11;
    localparam logic [3:0] LAST_IDX = 4'd10;
    localparam logic [7:0] COUNT_F  = 8'd11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DATA  = 3'd2,
        S_CKSUM = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          idx_q, idx_d;
    logic [SNAP_W-1:0]   snap_q, snap_d;
    logic [15:0]         seq_q, seq_d;

    logic                wr;
    logic [31:0]         hdr_word;
    logic [SNAP_W-1:0]   snap_shift;
    logic [31:0]         data_word;
`ifdef LATCH_DUMP_CHECKSUM_EN
    logic [31:0]         cksum_word;
`endif

    // State register and datapath flops; reset abandons any partial frame
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            snap_q  <= '0;
            seq_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            seq_q   <= seq_d;
        end
    end

    // Word sources: header, selected data word, and optional checksum
    always_comb begin
        hdr_word   = {MAGIC, COUNT_F, seq_q};
        snap_shift = snap_q >> {idx_q, 5'b00000};
        data_word  = snap_shift[31:0];
`ifdef LATCH_DUMP_CHECKSUM_EN
        cksum_word = hdr_word;
        for (int k = 0; k < N_DATA; k++) begin
            cksum_word = cksum_word ^ snap_q[k*32 +: 32];
        end
`endif
    end

    // Next-state logic; states that write a word advance only on an accepted write
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        seq_d   = seq_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    snap_d  = {2'b00, i_MEM_WB_latch, i_EX_MEM_latch,
                               i_ID_EX_latch, i_IF_ID_latch};
                    idx_d   = 4'd0;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (wr) begin
                    idx_d   = 4'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (wr) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = 4'd0;
`ifdef LATCH_DUMP_CHECKSUM_EN
                        state_d = S_CKSUM;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_CKSUM: begin
                if (wr) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                seq_d   = seq_q + 16'd1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state; the strobe is gated combinationally by full
    always_comb begin
        wr              = 1'b0;
        o_data_to_fifo  = '0;
        o_busy          = (state_q != S_IDLE);
        o_done          = (state_q == S_DONE);
        case (state_q)
            S_HDR: begin
                o_data_to_fifo = hdr_word;
                wr             = ~i_fifo_full;
            end
            S_DATA: begin
                o_data_to_fifo = data_word;
                wr             = ~i_fifo_full;
            end
`ifdef LATCH_DUMP_CHECKSUM_EN
            S_CKSUM: begin
                o_data_to_fifo = cksum_word;
                wr             = ~i_fifo_full;
            end
`endif
            default: begin
                o_data_to_fifo = '0;
            end
        endcase
        o_write_en_fifo = wr;
    end

endmodule

// File: tb/tb_latch_dump_serializer.sv
// Testbench for latch_dump_serializer.
// The scoreboard queue holds the expected FIFO words. A frame's words are
// pushed when its start request is driven, and each accepted strobe pops
// one word and compares it.
module tb_latch_dump_serializer;

`ifdef LATCH_DUMP_CHECKSUM_EN
    localparam int FRAME_N = 13;
    localparam bit CK      = 1'b1;
`else
    localparam int FRAME_N = 12;
    localparam bit CK      = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         i_reset;
    logic         i_start;
    logic [63:0]  if_id;
    logic [138:0] id_ex;
    logic [75:0]  ex_mem;
    logic [70:0]  mem_wb;
    logic         i_fifo_full;
    logic [31:0]  o_data;
    logic         o_wr;
    logic         o_busy;
    logic         o_done;

    always #5 clk = ~clk;

    latch_dump_serializer dut (
        .i_clk           (clk),
        .i_reset         (i_reset),
        .i_start         (i_start),
        .i_IF_ID_latch   (if_id),
        .i_ID_EX_latch   (id_ex),
        .i_EX_MEM_latch  (ex_mem),
        .i_MEM_WB_latch  (mem_wb),
        .i_fifo_full     (i_fifo_full),
        .o_data_to_fifo  (o_data),
        .o_write_en_fifo (o_wr),
        .o_busy          (o_busy),
        .o_done          (o_done)
    );

    typedef struct {
        logic [63:0]  if_id;
        logic [138:0] id_ex;
        logic [75:0]  ex_mem;
        logic [70:0]  mem_wb;
        logic [31:0]  full_mask;   // bit j: FIFO full for the cycle ending at edge E0+j
        int           mut_j;       // cycle at which latches go all-ones (0 = never)
        int           extra_start; // cycle of an ignored start pulse (0 = none)
        int           exp_done;    // o_done cycle, plain build
        int           exp_done_ck; // o_done cycle, checksum build
    } vec_t;

    vec_t        vecs[6];
    int          checks   = 0;
    int          failures = 0;
    int          strobes  = 0;
    logic [31:0] exp_q[$];
    logic [15:0] seq_m;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected frame built from the documented packing of the four latches
    task automatic push_frame(input logic [63:0] a, input logic [138:0] b,
                              input logic [75:0] c, input logic [70:0] d);
        logic [351:0] snap;
        logic [31:0]  w;
        logic [31:0]  x;
        snap = {2'b00, d, c, b, a};
        w = {8'hA5, 8'd11, seq_m};
        x = w;
        exp_q.push_back(w);
        for (int k = 0; k < 11; k++) begin
            w = snap[k*32 +: 32];
            x = x ^ w;
            exp_q.push_back(w);
        end
        if (CK) exp_q.push_back(x);
        seq_m = seq_m + 16'd1;
    endtask

    task automatic load_latches(input vec_t v);
        if_id  = v.if_id;
        id_ex  = v.id_ex;
        ex_mem = v.ex_mem;
        mem_wb = v.mem_wb;
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int done_j;
        int s0;
        int exp_d;
        done_j = -1;
        exp_d  = CK ? v.exp_done_ck : v.exp_done;
        @(negedge clk);
        load_latches(v);
        i_fifo_full = 1'b0;
        i_start     = 1'b1;
        push_frame(v.if_id, v.id_ex, v.ex_mem, v.mem_wb);
        s0 = strobes;
        @(posedge clk);
        for (int j = 1; j <= 40; j++) begin
            #1;
            i_fifo_full = (j < 32) ? v.full_mask[j] : 1'b0;
            i_start     = (j == v.extra_start);
            if (j == v.mut_j) begin
                if_id  = '1;
                id_ex  = '1;
                ex_mem = '1;
                mem_wb = '1;
            end
            @(negedge clk);
            if (i_fifo_full) check($sformatf("v%0d_stall_strobe_c%0d", n, j), o_wr, 0);
            if (o_done && done_j < 0) begin
                done_j = j;
                check($sformatf("v%0d_done_data_zero", n), o_data, 0);
            end
            if (done_j >= 0 && j == done_j + 1) begin
                check($sformatf("v%0d_idle_busy", n), o_busy, 0);
                break;
            end
            @(posedge clk);
        end
        i_fifo_full = 1'b0;
        i_start     = 1'b0;
        check($sformatf("v%0d_done_cycle", n), done_j, exp_d);
        check($sformatf("v%0d_strobe_count", n), strobes - s0, FRAME_N);
        check($sformatf("v%0d_sb_empty", n), exp_q.size(), 0);
    endtask

    initial begin
        vecs[0] = '{64'h01234567_89ABCDEF, '0, '0, '0, 32'h0, 0, 0, 13, 14};
        vecs[1] = '{64'h01234567_89ABCDEF, '0, '0, '0, 32'h38, 0, 0, 16, 17};
        vecs[2] = '{64'h01234567_89ABCDEF, '0, '0, '0, 32'h0, 2, 0, 13, 14};
        vecs[3] = '{64'h01234567_89ABCDEF, '0, '0, '0, 32'h0, 0, 4, 13, 14};
        vecs[4] = '{64'hDEADBEEF_CAFEF00D,
                    {11'h5A5, 64'h13579BDF_2468ACE0, 64'hFEDCBA98_76543210},
                    {12'hABC, 64'h0F1E2D3C_4B5A6978},
                    {7'h55, 64'h80000001_7FFFFFFE},
                    32'h1002, 0, 0, 15, 16};
        vecs[5] = '{64'hFFFFFFFF_00000001, {139{1'b1}}, '0, {71{1'b1}},
                    32'h2000, 0, 0, 13, 15};

        i_reset     = 1'b0;
        i_start     = 1'b0;
        i_fifo_full = 1'b0;
        if_id  = '0;
        id_ex  = '0;
        ex_mem = '0;
        mem_wb = '0;
        seq_m  = 16'h0000;

        fork
            begin : monitor
                logic [31:0] e_w;
                forever begin
                    @(negedge clk);
                    if (i_reset === 1'b1 && o_wr === 1'b1) begin
                        strobes++;
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL sb_unexpected actual=%0h required=no_strobe", o_data);
                        end else begin
                            e_w = exp_q.pop_front();
                            check("sb_word", o_data, e_w);
                        end
                    end
                end
            end
            begin : watchdog
                #2000000;
                $display("FAIL watchdog actual=timeout required=finish");
                $fatal(1, "watchdog");
            end
            begin : main
                int d1;
                int d2;
                int j;
                // Reset state and idle behaviour
                repeat (3) @(negedge clk);
                check("rst_wr", o_wr, 0);
                check("rst_busy", o_busy, 0);
                i_reset = 1'b1;
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    check("idle_wr", o_wr, 0);
                    check("idle_busy", o_busy, 0);
                    check("idle_done", o_done, 0);
                    check("idle_data", o_data, 0);
                end

                // Table-driven dumps
                for (int n = 0; n < 6; n++) run_vec(vecs[n], n);

                // i_start held through DONE: back-to-back dumps
                @(negedge clk);
                load_latches(vecs[4]);
                push_frame(vecs[4].if_id, vecs[4].id_ex, vecs[4].ex_mem, vecs[4].mem_wb);
                push_frame(vecs[4].if_id, vecs[4].id_ex, vecs[4].ex_mem, vecs[4].mem_wb);
                i_start = 1'b1;
                d1 = -1;
                d2 = -1;
                j  = 0;
                while (j < 60 && d2 < 0) begin
                    @(posedge clk);
                    j++;
                    #1;
                    if (d1 >= 0 && j == d1 + 2) i_start = 1'b0;
                    @(negedge clk);
                    if (o_done) begin
                        if (d1 < 0) d1 = j;
                        else d2 = j;
                    end
                end
                i_start = 1'b0;
                check("b2b_gap", d2 - d1, FRAME_N + 2);
                repeat (3) @(negedge clk);
                check("b2b_idle", o_busy, 0);
                check("b2b_sb_empty", exp_q.size(), 0);

                // Reset mid-dump
                @(negedge clk);
                load_latches(vecs[4]);
                push_frame(vecs[4].if_id, vecs[4].id_ex, vecs[4].ex_mem, vecs[4].mem_wb);
                i_start = 1'b1;
                @(posedge clk);
                #1 i_start = 1'b0;
                repeat (5) @(posedge clk);
                #2 i_reset = 1'b0;
                #1;
                check("mid_rst_wr", o_wr, 0);
                check("mid_rst_busy", o_busy, 0);
                check("mid_rst_data", o_data, 0);
                exp_q.delete();
                seq_m = 16'h0000;
                @(negedge clk);
                i_reset = 1'b1;
                repeat (3) @(negedge clk);
                run_vec(vecs[0], 6);

                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        join_any
    end

endmodule
